// File: rtl/risc16_mem_arb_if.sv
// Bus bundle for risc16_mem_arb: core data port, host req/ack port,
// memory macro port and statistics counters.
interface risc16_mem_arb_if #(
  parameter int unsigned ADDR_W = 15
);
  logic [15:0]       core_addr;
  logic              core_oe;
  logic              core_we;
  logic [15:0]       core_wdata;
  logic [15:0]       core_rdata;

  logic              h_req;
  logic              h_we;
  logic [15:0]       h_addr;
  logic [15:0]       h_wdata;
  logic              h_ack;
  logic [15:0]       h_rdata;
  logic              h_busy;
  logic              h_starve;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  logic              stats_clr;
  logic [15:0]       st_core_rd;
  logic [15:0]       st_core_wr;
  logic [15:0]       st_host;
  logic [15:0]       st_host_wait;

  modport slave (
    input  core_addr, core_oe, core_we, core_wdata,
    output core_rdata,
    input  h_req, h_we, h_addr, h_wdata,
    output h_ack, h_rdata, h_busy, h_starve,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    input  stats_clr,
    output st_core_rd, st_core_wr, st_host, st_host_wait
  );

  modport master (
    output core_addr, core_oe, core_we, core_wdata,
    input  core_rdata,
    output h_req, h_we, h_addr, h_wdata,
    input  h_ack, h_rdata, h_busy, h_starve,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    output stats_clr,
    input  st_core_rd, st_core_wr, st_host, st_host_wait
  );
endinterface

// File: rtl/risc16_mem_arb.sv
// Core/host arbiter for the risc16f data memory; core always wins, host is queued one deep.
// Optional statistics counters are enabled by defining RISC16_MEM_ARB_STATS_EN.
module risc16_mem_arb #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input logic             clk,
  input logic             rst,
  risc16_mem_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

  state_t            state;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_wdata;
  logic [15:0]       wait_cnt;
  logic [15:0]       h_rdata_q;

  logic core_act;
  logic host_issue;
  logic unused_bits;

  assign core_act   = bus.core_oe | bus.core_we;
  // Gated by rst so a request discarded by reset never reaches the memory.
  assign host_issue = (state == PEND) && !core_act && !rst;

  assign unused_bits = ^{bus.core_addr, bus.h_addr, bus.stats_clr};

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.core_addr[ADDR_W:1];
    bus.mem_wdata = bus.core_wdata;
    if (core_act) begin
      bus.mem_en = 1'b1;
      bus.mem_we = bus.core_we;
    end else if (host_issue) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = lat_we;
      bus.mem_addr  = lat_addr;
      bus.mem_wdata = lat_wdata;
    end
  end

  assign bus.core_rdata = bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      h_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.h_req) begin
            lat_we    <= bus.h_we;
            lat_addr  <= bus.h_addr[ADDR_W:1];
            lat_wdata <= bus.h_wdata;
            wait_cnt  <= '0;
            state     <= PEND;
          end
        end
        PEND: begin
          if (core_act) begin
            if (wait_cnt != '1)
              wait_cnt <= wait_cnt + 16'd1;
          end else begin
            if (!lat_we)
              h_rdata_q <= bus.mem_rdata;
            state <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.h_ack    = (state == ACK);
  assign bus.h_busy   = (state != IDLE);
  assign bus.h_starve = (state == PEND) && (wait_cnt >= 16'(STARVE_LIMIT));
  assign bus.h_rdata  = h_rdata_q;

`ifdef RISC16_MEM_ARB_STATS_EN
  logic [15:0] st_rd_q, st_wr_q, st_host_q, st_wait_q;

  always_ff @(posedge clk) begin
    if (rst || bus.stats_clr) begin
      st_rd_q   <= '0;
      st_wr_q   <= '0;
      st_host_q <= '0;
      st_wait_q <= '0;
    end else begin
      if (bus.core_oe && !bus.core_we) st_rd_q   <= st_rd_q + 16'd1;
      if (bus.core_we)                 st_wr_q   <= st_wr_q + 16'd1;
      if (host_issue)                  st_host_q <= st_host_q + 16'd1;
      if ((state == PEND) && core_act) st_wait_q <= st_wait_q + 16'd1;
    end
  end

  assign bus.st_core_rd   = st_rd_q;
  assign bus.st_core_wr   = st_wr_q;
  assign bus.st_host      = st_host_q;
  assign bus.st_host_wait = st_wait_q;
`else
  assign bus.st_core_rd   = '0;
  assign bus.st_core_wr   = '0;
  assign bus.st_host      = '0;
  assign bus.st_host_wait = '0;
`endif

endmodule

// File: tb/tb_risc16_mem_arb.sv
// Self-checking bench for risc16_mem_arb: directed scenarios, then random
// core/host traffic against a transaction-level reference model.
module tb_risc16_mem_arb;
  localparam int unsigned AW  = 8;
  localparam int unsigned LIM = 4;
`ifdef RISC16_MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clr_mem;
  always #5 clk = ~clk;

  risc16_mem_arb_if #(.ADDR_W(AW)) bus ();
  risc16_mem_arb #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory macro stand-in: synchronous write, asynchronous read.
  logic [15:0] phys [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < (1<<AW); i++) phys[i] <= '0;
    end else if (bus.mem_en && bus.mem_we) begin
      phys[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = phys[bus.mem_addr];

  // Reference model: golden memory plus one outstanding host transaction.
  logic [15:0]   gold [0:(1<<AW)-1];
  bit            m_pend, m_ack, m_we;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_wdata, m_hrdata;
  int            m_wait;
  logic [15:0]   s_rd, s_wr, s_host, s_wait;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] widx(input logic [15:0] a);
    return a[AW:1];
  endfunction

  task automatic settle();
    bit act;
    #1;
    act = bus.core_oe | bus.core_we;
    check("h_busy", bus.h_busy, m_pend | m_ack);
    check("h_ack", bus.h_ack, m_ack);
    check("h_starve", bus.h_starve, m_pend && (m_wait >= LIM));
    check("h_rdata", bus.h_rdata, m_hrdata);
    if (act) begin
      check("core_en", bus.mem_en, 1);
      check("core_we", bus.mem_we, bus.core_we);
      check("core_maddr", bus.mem_addr, widx(bus.core_addr));
      if (bus.core_we) check("core_mwdata", bus.mem_wdata, bus.core_wdata);
      else check("core_rdata", bus.core_rdata, gold[widx(bus.core_addr)]);
    end else if (m_pend && !rst) begin
      check("host_en", bus.mem_en, 1);
      check("host_we", bus.mem_we, m_we);
      check("host_maddr", bus.mem_addr, m_addr);
      if (m_we) check("host_mwdata", bus.mem_wdata, m_wdata);
    end else begin
      check("idle_en", bus.mem_en, 0);
    end
    check("st_core_rd", bus.st_core_rd, STATS ? s_rd : 16'd0);
    check("st_core_wr", bus.st_core_wr, STATS ? s_wr : 16'd0);
    check("st_host", bus.st_host, STATS ? s_host : 16'd0);
    check("st_host_wait", bus.st_host_wait, STATS ? s_wait : 16'd0);
  endtask

  task automatic model_update();
    bit act, issue, waited;
    act    = bus.core_oe | bus.core_we;
    issue  = m_pend && !act && !rst;
    waited = m_pend && act;
    if (bus.core_we) gold[widx(bus.core_addr)] = bus.core_wdata;
    else if (issue && m_we) gold[m_addr] = m_wdata;
    if (rst || bus.stats_clr) begin
      s_rd = 0; s_wr = 0; s_host = 0; s_wait = 0;
    end else begin
      s_rd   += 16'(bus.core_oe && !bus.core_we);
      s_wr   += 16'(bus.core_we);
      s_host += 16'(issue);
      s_wait += 16'(waited);
    end
    if (rst) begin
      m_pend = 0; m_ack = 0; m_wait = 0; m_hrdata = '0;
    end else if (m_ack) begin
      m_ack = 0;
    end else if (m_pend) begin
      if (issue) begin
        if (!m_we) m_hrdata = gold[m_addr];
        m_pend = 0;
        m_ack  = 1;
      end else if (m_wait < 65535) begin
        m_wait++;
      end
    end else if (bus.h_req) begin
      m_pend  = 1;
      m_we    = bus.h_we;
      m_addr  = widx(bus.h_addr);
      m_wdata = bus.h_wdata;
      m_wait  = 0;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; clr_mem = 1;
    bus.core_addr = '0; bus.core_oe = 0; bus.core_we = 0; bus.core_wdata = '0;
    bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;
    bus.stats_clr = 0;
    for (int i = 0; i < (1<<AW); i++) gold[i] = '0;
    m_pend = 0; m_ack = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_hrdata = '0; m_wait = 0;
    s_rd = 0; s_wr = 0; s_host = 0; s_wait = 0;
    advance();
    advance();
    clr_mem = 0;
    settle();
    check("rst_busy", bus.h_busy, 0);
    check("rst_ack", bus.h_ack, 0);
    check("rst_rdata", bus.h_rdata, 0);
    advance();
    rst = 0;

    // Core store then load
    bus.core_we = 1; bus.core_addr = 16'h0010; bus.core_wdata = 16'hBEEF;
    settle();
    check("store_addr", bus.mem_addr, 8'h08);
    check("store_we", bus.mem_we, 1);
    advance();
    bus.core_we = 0; bus.core_oe = 1;
    settle();
    check("load_data", bus.core_rdata, 16'hBEEF);
    advance();
    bus.core_oe = 0;

    // Host write on idle bus: access cycle 1, ack cycle 2
    bus.h_req = 1; bus.h_we = 1; bus.h_addr = 16'h0020; bus.h_wdata = 16'h1234;
    settle(); check("hw_c0_en", bus.mem_en, 0); advance();
    bus.h_wdata = 16'hFFFF;
    settle(); check("hw_c1_en", bus.mem_en, 1); check("hw_c1_wdata", bus.mem_wdata, 16'h1234); advance();
    bus.h_req = 0;
    settle(); check("hw_c2_ack", bus.h_ack, 1); advance();

    // Host read back
    bus.h_req = 1; bus.h_we = 0; bus.h_addr = 16'h0020;
    settle(); advance();
    settle(); advance();
    bus.h_req = 0;
    settle(); check("hr_ack", bus.h_ack, 1); check("hr_data", bus.h_rdata, 16'h1234); advance();

    // Collision: host read pending under 3 core loads
    bus.stats_clr = 1; bus.h_req = 1; bus.h_we = 0; bus.h_addr = 16'h0010;
    settle(); advance();
    bus.stats_clr = 0;
    for (int k = 1; k <= 3; k++) begin
      bus.core_oe = 1; bus.core_addr = 16'h0020;
      settle(); check("col_load", bus.core_rdata, 16'h1234); check("col_noack", bus.h_ack, 0);
      advance();
    end
    bus.core_oe = 0;
    settle(); check("col_issue", bus.mem_en, 1); check("col_iaddr", bus.mem_addr, 8'h08); advance();
    bus.h_req = 0;
    settle();
    check("col_ack", bus.h_ack, 1);
    check("col_data", bus.h_rdata, 16'hBEEF);
    check("col_wait", bus.st_host_wait, STATS ? 16'd3 : 16'd0);
    advance();

    // Starvation with LIM=4
    bus.h_req = 1; bus.h_we = 1; bus.h_addr = 16'h0040; bus.h_wdata = 16'h5555;
    settle(); advance();
    for (int k = 1; k <= 6; k++) begin
      bus.core_oe = 1; bus.core_addr = 16'h0000;
      settle(); check("starve_k", bus.h_starve, (k >= 5));
      advance();
    end
    bus.core_oe = 0;
    settle(); check("starve_issue", bus.h_starve, 1); advance();
    bus.h_req = 0;
    settle(); check("starve_clr", bus.h_starve, 0); check("starve_ack", bus.h_ack, 1); advance();

    // Reset while pending
    bus.h_req = 1; bus.h_we = 1; bus.h_addr = 16'h0030; bus.h_wdata = 16'hDEAD;
    settle(); advance();
    rst = 1;
    settle(); check("rstp_noen", bus.mem_en, 0); advance();
    rst = 0; bus.h_req = 0;
    settle(); check("rstp_busy", bus.h_busy, 0); check("rstp_ack", bus.h_ack, 0); advance();
    settle(); check("rstp_ack2", bus.h_ack, 0); advance();
    bus.core_oe = 1; bus.core_addr = 16'h0030;
    settle(); check("rstp_mem", bus.core_rdata, 16'h0000); advance();
    bus.core_oe = 0;

    // Stats: 5 loads, then clear
    bus.stats_clr = 1; settle(); advance();
    bus.stats_clr = 0;
    for (int k = 0; k < 5; k++) begin
      bus.core_oe = 1; bus.core_addr = 16'($urandom);
      settle(); advance();
    end
    bus.core_oe = 0;
    settle(); check("st_rd5", bus.st_core_rd, STATS ? 16'd5 : 16'd0);
    bus.stats_clr = 1; advance();
    bus.stats_clr = 0;
    settle(); check("st_rd0", bus.st_core_rd, 16'd0); advance();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      rst = ($urandom_range(0, 199) == 0);
      bus.stats_clr = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 7);
      bus.core_oe    = (r == 1 || r == 2 || r == 3 || r == 5);
      bus.core_we    = (r == 4 || r == 5);
      bus.core_addr  = 16'($urandom);
      bus.core_wdata = 16'($urandom);
      if (m_ack) bus.h_req = ($urandom_range(0, 3) == 0);
      else if (m_pend) bus.h_req = 1;
      else bus.h_req = ($urandom_range(0, 2) == 0);
      bus.h_we    = $urandom_range(0, 1) != 0;
      bus.h_addr  = 16'($urandom);
      bus.h_wdata = 16'($urandom);
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
